spi_slave_word: RTL



---
 rtl/spi_slave_word.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/spi_slave_word.sv
// spi_slave_word: oversampled SPI slave for all four CPOL/CPHA modes.
// Receives WIDTH-bit words MSB first, counts completed words per transaction,
// requests transmit words through a tx_req/tx_valid handshake and reports
// framing errors when chip select is released mid-word.
module spi_slave_word #(
  parameter int WIDTH = 8,
  parameter int CPOL  = 0,
  parameter int CPHA  = 0,
  parameter int CNT_W = 8,
  parameter int SYNC  = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_sck,
  input  logic             i_cs_n,
  input  logic             i_mosi,
  output logic             o_miso,
  output logic             o_miso_oe,
  output logic             o_rx_valid,
  output logic [WIDTH-1:0] o_rx_data,
  output logic [CNT_W-1:0] o_rx_cnt,
  output logic             o_tx_req,
  input  logic [WIDTH-1:0] i_tx_data,
  input  logic             i_tx_valid,
  output logic             o_tx_underrun,
  output logic             o_xfer_end,
  output logic             o_frame_err
);

  localparam int BW     = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam int WARM_W = $clog2(SYNC + 2);
  localparam logic SCK_IDLE = 1'(CPOL);

  // Synchroniser chains and previous-value registers for edge detection
  logic [SYNC-1:0]   r_sck_sync;
  logic [SYNC-1:0]   r_cs_sync;
  logic [SYNC-1:0]   r_mosi_sync;
  logic              r_sck_prev;
  logic              r_cs_prev;

  // Arming logic: chain contents are only trusted once refilled after reset
  logic [WARM_W-1:0] r_warm;
  logic              r_armed;

  // Transaction state
  logic              r_active;
  logic [BW-1:0]     r_bitcnt;
  logic [WIDTH-1:0]  r_rx_shift;
  logic [WIDTH-1:0]  r_rx_data;
  logic [WIDTH-1:0]  r_tx_shift;
  logic [CNT_W-1:0]  r_rx_cnt;
  logic              r_rx_valid;
  logic              r_tx_underrun;
  logic              r_xfer_end;
  logic              r_frame_err;

  // Decoded strobes
  logic w_sck_s;
  logic w_cs_s;
  logic w_mosi_s;
  logic w_sck_rise;
  logic w_sck_fall;
  logic w_lead_edge;
  logic w_trail_edge;
  logic w_sample_edge;
  logic w_shift_edge;
  logic w_cs_fall;
  logic w_cs_rise;
  logic w_warm_done;
  logic w_start;
  logic w_stop;
  logic w_sample;
  logic w_shift;
  logic w_word_done;
  logic w_load;
  logic [WIDTH-1:0] w_tx_next;
  logic [WIDTH-1:0] w_rx_next;

  assign w_sck_s  = r_sck_sync[SYNC-1];
  assign w_cs_s   = r_cs_sync[SYNC-1];
  assign w_mosi_s = r_mosi_sync[SYNC-1];

  assign w_sck_rise   = ~r_sck_prev & w_sck_s;
  assign w_sck_fall   = r_sck_prev & ~w_sck_s;
  assign w_lead_edge  = (CPOL == 0) ? w_sck_rise : w_sck_fall;
  assign w_trail_edge = (CPOL == 0) ? w_sck_fall : w_sck_rise;
  assign w_sample_edge = (CPHA == 0) ? w_lead_edge : w_trail_edge;
  assign w_shift_edge  = (CPHA == 0) ? w_trail_edge : w_lead_edge;

  assign w_cs_fall   = r_cs_prev & ~w_cs_s;
  assign w_cs_rise   = ~r_cs_prev & w_cs_s;
  assign w_warm_done = (r_warm == WARM_W'(SYNC + 1));

  // Deassertion has priority over a coincident sample edge
  assign w_start     = r_armed & ~r_active & w_cs_fall;
  assign w_stop      = r_active & w_cs_rise;
  assign w_sample    = r_active & ~w_cs_rise & w_sample_edge;
  assign w_shift     = r_active & ~w_cs_rise & w_shift_edge;
  assign w_word_done = w_sample & (r_bitcnt == BW'(WIDTH - 1));
  assign w_load      = w_start | w_word_done;

  // A missing tx word is replaced by zeros on the wire
  assign w_tx_next = i_tx_valid ? i_tx_data : {WIDTH{1'b0}};
  assign w_rx_next = {r_rx_shift[WIDTH-2:0], w_mosi_s};

  // Synchronise the asynchronous pins; reset levels produce no false edges
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sck_sync  <= {SYNC{SCK_IDLE}};
      r_cs_sync   <= {SYNC{1'b1}};
      r_mosi_sync <= {SYNC{1'b0}};
      r_sck_prev  <= SCK_IDLE;
      r_cs_prev   <= 1'b1;
    end else begin
      r_sck_sync  <= {r_sck_sync[SYNC-2:0], i_sck};
      r_cs_sync   <= {r_cs_sync[SYNC-2:0], i_cs_n};
      r_mosi_sync <= {r_mosi_sync[SYNC-2:0], i_mosi};
      r_sck_prev  <= w_sck_s;
      r_cs_prev   <= w_cs_s;
    end
  end

  // Arm only after a genuinely sampled high cs_n so reset mid-transfer aborts silently
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_warm  <= '0;
      r_armed <= 1'b0;
    end else begin
      if (!w_warm_done) begin
        r_warm <= r_warm + WARM_W'(1);
      end else begin
        r_warm <= r_warm;
      end
      if (w_warm_done && w_cs_s) begin
        r_armed <= 1'b1;
      end else begin
        r_armed <= r_armed;
      end
    end
  end

  // Transaction control: active flag, bit/word counters, status pulses
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_active      <= 1'b0;
      r_bitcnt      <= '0;
      r_rx_cnt      <= '0;
      r_rx_valid    <= 1'b0;
      r_tx_underrun <= 1'b0;
      r_xfer_end    <= 1'b0;
      r_frame_err   <= 1'b0;
    end else begin
      r_rx_valid  <= 1'b0;
      r_xfer_end  <= 1'b0;
      r_frame_err <= 1'b0;
      if (w_start) begin
        r_active      <= 1'b1;
        r_bitcnt      <= '0;
        r_rx_cnt      <= '0;
        r_tx_underrun <= ~i_tx_valid;
      end else if (w_stop) begin
        r_active    <= 1'b0;
        r_xfer_end  <= 1'b1;
        // a dropped coincident sample also leaves the word incomplete
        r_frame_err <= (r_bitcnt != '0) | w_sample_edge;
        r_bitcnt    <= '0;
      end else if (w_sample) begin
        if (w_word_done) begin
          r_bitcnt   <= '0;
          r_rx_valid <= 1'b1;
          r_rx_cnt   <= r_rx_cnt + CNT_W'(1);
          if (!i_tx_valid) begin
            r_tx_underrun <= 1'b1;
          end else begin
            r_tx_underrun <= r_tx_underrun;
          end
        end else begin
          r_bitcnt <= r_bitcnt + BW'(1);
        end
      end else begin
        r_active <= r_active;
        r_bitcnt <= r_bitcnt;
      end
    end
  end

  // Receive path: shift on sample edges, publish completed words
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rx_shift <= '0;
      r_rx_data  <= '0;
    end else if (w_stop) begin
      r_rx_shift <= '0;
    end else if (w_sample) begin
      r_rx_shift <= w_rx_next;
      if (w_word_done) begin
        r_rx_data <= w_rx_next;
      end else begin
        r_rx_data <= r_rx_data;
      end
    end else begin
      r_rx_shift <= r_rx_shift;
    end
  end

  // Transmit path: load on request, shift except right after a fresh load
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_tx_shift <= '0;
    end else if (w_load) begin
      r_tx_shift <= w_tx_next;
    end else if (w_stop) begin
      r_tx_shift <= '0;
    end else if (w_shift && (r_bitcnt != '0)) begin
      r_tx_shift <= {r_tx_shift[WIDTH-2:0], 1'b0};
    end else begin
      r_tx_shift <= r_tx_shift;
    end
  end

  // tx_req is decoded from registers only, so the load and the request share a cycle
  assign o_tx_req      = w_load;
  assign o_miso        = r_tx_shift[WIDTH-1];
  assign o_miso_oe     = r_active;
  assign o_rx_valid    = r_rx_valid;
  assign o_rx_data     = r_rx_data;
  assign o_rx_cnt      = r_rx_cnt;
  assign o_tx_underrun = r_tx_underrun;
  assign o_xfer_end    = r_xfer_end;
  assign o_frame_err   = r_frame_err;

endmodule
